// File: rtl/uart_frame_parser_pkg.sv
// uart_frame_pkg: shared constants and types for the UART frame parser.
//   SOF           - start-of-frame byte
//   state_e       - parser FSM state encoding
//   ERR_*         - err_code values reported with err_pulse
//   sat_inc16     - saturating 16-bit increment used by the frame counters
package uart_frame_pkg;

    localparam logic [7:0] SOF = 8'hAA;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_LEN     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CHK     = 3'd4,
        ST_HOLD    = 3'd5
    } state_e;

    localparam logic [1:0] ERR_LEN = 2'd1;
    localparam logic [1:0] ERR_CHK = 2'd2;
    localparam logic [1:0] ERR_TMO = 2'd3;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            sat_inc16 = v;
        end else begin
            sat_inc16 = v + 16'd1;
        end
    endfunction

endpackage

// File: rtl/frame_payload_ram.sv
// frame_payload_ram: simple dual-port DEPTH x 8 payload store, written by the
// parser and read by the command layer. The read is registered so the array
// maps onto block RAM; the array itself has no reset.
//   clk      - clock
//   we_i     - write enable
//   waddr_i  - write address
//   wdata_i  - write data
//   raddr_i  - read address
//   rdata_o  - read data, valid one cycle after raddr_i
module frame_payload_ram #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [7:0]        wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [7:0]        rdata_o
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rdata_q;

    // Write port and registered read port.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/uart_frame_parser.sv
// uart_frame_parser: pops bytes from the UART RX FIFO, finds frames of the
// form SOF CMD LEN payload[LEN] CHK (CHK = XOR of CMD, LEN, payload), and
// holds each good frame for the command layer until frame_ack.
//   clk, rst               - clock, synchronous active-high reset
//   fifo_rd_en/dout/empty  - RX FIFO read handshake (data valid 1 cycle after pop)
//   frame_valid/cmd/len    - held good frame
//   buf_raddr/buf_rdata    - payload read port (registered read)
//   frame_ack              - releases the held frame
//   err_pulse/err_code     - drop report (1 = LEN too big, 2 = bad CHK, 3 = timeout)
//   good_cnt/err_cnt       - saturating frame counters
module uart_frame_parser
    import uart_frame_pkg::*;
#(
    parameter int MAX_LEN      = 64,
    parameter int TIMEOUT_CLKS = 480000,
    parameter int ADDR_W       = 6
) (
    input  logic              clk,
    input  logic              rst,
    output logic              fifo_rd_en,
    input  logic [7:0]        fifo_dout,
    input  logic              fifo_empty,
    output logic              frame_valid,
    output logic [7:0]        frame_cmd,
    output logic [7:0]        frame_len,
    input  logic [ADDR_W-1:0] buf_raddr,
    output logic [7:0]        buf_rdata,
    input  logic              frame_ack,
    output logic              err_pulse,
    output logic [1:0]        err_code,
    output logic [15:0]       good_cnt,
    output logic [15:0]       err_cnt
);

    localparam int              TMO_W     = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CLKS - 1);
    localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);

    state_e           state_q;
    logic             rd_en_q;      // pop issued this cycle (the pending pop)
    logic             byte_vld_q;   // fifo_dout holds the popped byte this cycle
    logic [7:0]       chk_acc_q;
    logic [7:0]       idx_q;
    logic [TMO_W-1:0] tmo_q;
    logic             frame_valid_q;
    logic [7:0]       frame_cmd_q;
    logic [7:0]       frame_len_q;
    logic             err_pulse_q;
    logic [1:0]       err_code_q;
    logic [15:0]      good_cnt_q;
    logic [15:0]      err_cnt_q;

    logic             pop_d;
    logic             active_s;
    logic             tmo_hit_s;
    logic             to_hold_s;
    logic             drop_s;
    logic [1:0]       drop_code_s;
    logic             ram_we_s;

    assign active_s  = (state_q == ST_CMD) || (state_q == ST_LEN) ||
                       (state_q == ST_PAYLOAD) || (state_q == ST_CHK);
    // A byte arriving in the expiry cycle wins over the timeout.
    assign tmo_hit_s = active_s && !byte_vld_q && (tmo_q == TMO_LAST);
    assign to_hold_s = byte_vld_q && (state_q == ST_CHK) && (fifo_dout == chk_acc_q);
    // No pop in HOLD, including the edge that enters HOLD.
    assign pop_d     = !fifo_empty && !rd_en_q && (state_q != ST_HOLD) && !to_hold_s;
    assign ram_we_s  = byte_vld_q && (state_q == ST_PAYLOAD);

    // Drop detection and cause.
    always_comb begin
        drop_s      = 1'b0;
        drop_code_s = ERR_TMO;
        if (tmo_hit_s) begin
            drop_s      = 1'b1;
            drop_code_s = ERR_TMO;
        end else if (byte_vld_q && (state_q == ST_LEN) && (fifo_dout > MAX_LEN_B)) begin
            drop_s      = 1'b1;
            drop_code_s = ERR_LEN;
        end else if (byte_vld_q && (state_q == ST_CHK) && (fifo_dout != chk_acc_q)) begin
            drop_s      = 1'b1;
            drop_code_s = ERR_CHK;
        end else begin
            drop_s      = 1'b0;
            drop_code_s = ERR_TMO;
        end
    end

    // Parser FSM, pop handshake, timeout, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            rd_en_q       <= 1'b0;
            byte_vld_q    <= 1'b0;
            chk_acc_q     <= 8'h00;
            idx_q         <= 8'h00;
            tmo_q         <= '0;
            frame_valid_q <= 1'b0;
            frame_cmd_q   <= 8'h00;
            frame_len_q   <= 8'h00;
            err_pulse_q   <= 1'b0;
            err_code_q    <= 2'd0;
            good_cnt_q    <= 16'h0000;
            err_cnt_q     <= 16'h0000;
        end else begin
            rd_en_q     <= pop_d;
            byte_vld_q  <= rd_en_q;
            err_pulse_q <= 1'b0;

            if (byte_vld_q || !active_s) begin
                tmo_q <= '0;
            end else begin
                tmo_q <= tmo_q + TMO_W'(1);
            end

            if (drop_s) begin
                err_pulse_q <= 1'b1;
                err_code_q  <= drop_code_s;
                err_cnt_q   <= sat_inc16(err_cnt_q);
                state_q     <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (byte_vld_q && (fifo_dout == SOF)) begin
                            state_q <= ST_CMD;
                        end
                    end
                    ST_CMD: begin
                        if (byte_vld_q) begin
                            frame_cmd_q <= fifo_dout;
                            chk_acc_q   <= fifo_dout;
                            state_q     <= ST_LEN;
                        end
                    end
                    ST_LEN: begin
                        if (byte_vld_q) begin
                            frame_len_q <= fifo_dout;
                            chk_acc_q   <= chk_acc_q ^ fifo_dout;
                            idx_q       <= 8'h00;
                            state_q     <= (fifo_dout == 8'h00) ? ST_CHK : ST_PAYLOAD;
                        end
                    end
                    ST_PAYLOAD: begin
                        if (byte_vld_q) begin
                            chk_acc_q <= chk_acc_q ^ fifo_dout;
                            idx_q     <= idx_q + 8'd1;
                            if (idx_q == (frame_len_q - 8'd1)) begin
                                state_q <= ST_CHK;
                            end
                        end
                    end
                    ST_CHK: begin
                        // Mismatch is handled by the drop path above.
                        if (byte_vld_q) begin
                            frame_valid_q <= 1'b1;
                            good_cnt_q    <= sat_inc16(good_cnt_q);
                            state_q       <= ST_HOLD;
                        end
                    end
                    ST_HOLD: begin
                        if (frame_ack) begin
                            frame_valid_q <= 1'b0;
                            state_q       <= ST_IDLE;
                        end
                    end
                    default: begin
                        frame_valid_q <= 1'b0;
                        state_q       <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    frame_payload_ram #(
        .DEPTH  (MAX_LEN),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we_s),
        .waddr_i (idx_q[ADDR_W-1:0]),
        .wdata_i (fifo_dout),
        .raddr_i (buf_raddr),
        .rdata_o (buf_rdata)
    );

    assign fifo_rd_en  = rd_en_q;
    assign frame_valid = frame_valid_q;
    assign frame_cmd   = frame_cmd_q;
    assign frame_len   = frame_len_q;
    assign err_pulse   = err_pulse_q;
    assign err_code    = err_code_q;
    assign good_cnt    = good_cnt_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser with a behavioural RX FIFO model.
module tb_uart_frame_parser;

    localparam int MAX_LEN = 64;
    localparam int TMO     = 40;
    localparam int ADDR_W  = 6;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              fifo_rd_en;
    logic [7:0]        fifo_dout = 8'h00;
    logic              fifo_empty;
    logic              frame_valid;
    logic [7:0]        frame_cmd;
    logic [7:0]        frame_len;
    logic [ADDR_W-1:0] buf_raddr = '0;
    logic [7:0]        buf_rdata;
    logic              frame_ack = 1'b0;
    logic              err_pulse;
    logic [1:0]        err_code;
    logic [15:0]       good_cnt;
    logic [15:0]       err_cnt;

    uart_frame_parser #(
        .MAX_LEN      (MAX_LEN),
        .TIMEOUT_CLKS (TMO),
        .ADDR_W       (ADDR_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fifo_rd_en  (fifo_rd_en),
        .fifo_dout   (fifo_dout),
        .fifo_empty  (fifo_empty),
        .frame_valid (frame_valid),
        .frame_cmd   (frame_cmd),
        .frame_len   (frame_len),
        .buf_raddr   (buf_raddr),
        .buf_rdata   (buf_rdata),
        .frame_ack   (frame_ack),
        .err_pulse   (err_pulse),
        .err_code    (err_code),
        .good_cnt    (good_cnt),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    // RX FIFO model: bench pushes, DUT pops; data appears the cycle after the pop.
    logic [7:0] fifo_mem [0:255];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en && (rd_ptr != wr_ptr)) begin
            fifo_dout <= fifo_mem[rd_ptr[7:0]];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    // Output monitor sampled on the falling edge.
    int         cyc = 0;
    int         err_seen = 0;
    int         err_cyc = 0;
    int         last_rd_cyc = 0;
    int         pop_in_hold = 0;
    logic [1:0] last_code = 2'd0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rd_en) last_rd_cyc <= cyc;
        if (err_pulse) begin
            err_seen  <= err_seen + 1;
            err_cyc   <= cyc;
            last_code <= err_code;
        end
        if (fifo_rd_en && frame_valid) pop_in_hold <= pop_in_hold + 1;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        fifo_mem[wr_ptr[7:0]] = b;
        wr_ptr++;
    endtask

    // Push n bytes, first byte in the most significant used position.
    task automatic push_bytes(input logic [63:0] bytes, input int n);
        for (int i = n - 1; i >= 0; i--) push(bytes[i*8 +: 8]);
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 300; i++) begin
            if (frame_valid) break;
            tick();
        end
        check_eq({tag, "_valid"}, 32'(frame_valid), 32'd1);
    endtask

    task automatic drain(input int extra);
        for (int i = 0; i < 300; i++) begin
            if (rd_ptr == wr_ptr) break;
            tick();
        end
        for (int i = 0; i < extra; i++) tick();
    endtask

    task automatic read_buf(input logic [ADDR_W-1:0] addr, output logic [7:0] data);
        buf_raddr = addr;
        tick();
        data = buf_rdata;
    endtask

    task automatic ack(input string tag);
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        check_eq({tag, "_ack_clr"}, 32'(frame_valid), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_rd_en"},   32'(fifo_rd_en),  32'd0);
        check_eq({tag, "_valid"},   32'(frame_valid), 32'd0);
        check_eq({tag, "_errp"},    32'(err_pulse),   32'd0);
        check_eq({tag, "_cmd"},     32'(frame_cmd),   32'd0);
        check_eq({tag, "_len"},     32'(frame_len),   32'd0);
        check_eq({tag, "_errcode"}, 32'(err_code),    32'd0);
        check_eq({tag, "_good"},    32'(good_cnt),    32'd0);
        check_eq({tag, "_errcnt"},  32'(err_cnt),     32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        int         e0;
        int         p0;
        int         r0;

        // Reset
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_reset_vals("reset");

        // Good frame
        push_bytes(64'h00AA010310203002, 7);
        wait_valid("good");
        check_eq("good_cmd", 32'(frame_cmd), 32'h01);
        check_eq("good_len", 32'(frame_len), 32'd3);
        read_buf(6'd0, d); check_eq("good_buf0", 32'(d), 32'h10);
        read_buf(6'd1, d); check_eq("good_buf1", 32'(d), 32'h20);
        read_buf(6'd2, d); check_eq("good_buf2", 32'(d), 32'h30);
        check_eq("good_cnt1", 32'(good_cnt), 32'd1);
        check_eq("good_noerr", 32'(err_seen), 32'd0);
        ack("good");

        // Bad checksum
        push_bytes(64'h00AA010310203003, 7);
        drain(4);
        check_eq("badchk_pulses", 32'(err_seen), 32'd1);
        check_eq("badchk_code", 32'(last_code), 32'd2);
        check_eq("badchk_cnt", 32'(err_cnt), 32'd1);
        check_eq("badchk_valid", 32'(frame_valid), 32'd0);

        // LEN = 0
        push_bytes(64'h00000000AA050005, 4);
        wait_valid("len0");
        check_eq("len0_cmd", 32'(frame_cmd), 32'h05);
        check_eq("len0_len", 32'(frame_len), 32'd0);
        ack("len0");

        // Oversize LEN (0x41 = 65 > 64)
        push_bytes(64'h0000000000AA0141, 3);
        drain(4);
        check_eq("biglen_pulses", 32'(err_seen), 32'd2);
        check_eq("biglen_code", 32'(last_code), 32'd1);
        check_eq("biglen_cnt", 32'(err_cnt), 32'd2);

        // Garbage then a frame: hunting for SOF resumes after the drop
        push_bytes(64'h005500AA02017E7D, 7);
        wait_valid("garb");
        check_eq("garb_cmd", 32'(frame_cmd), 32'h02);
        check_eq("garb_len", 32'(frame_len), 32'd1);
        read_buf(6'd0, d); check_eq("garb_buf0", 32'(d), 32'h7E);
        check_eq("garb_noerr", 32'(err_seen), 32'd2);
        check_eq("garb_good", 32'(good_cnt), 32'd3);
        ack("garb");

        // Timeout: AA 01 then silence
        e0 = err_seen;
        push_bytes(64'h000000000000AA01, 2);
        for (int i = 0; i < 300; i++) begin
            if (err_seen != e0) break;
            tick();
        end
        check_eq("tmo_pulses", 32'(err_seen), 32'(e0 + 1));
        // Pop seen at cycle n, byte consumed at the edge after n+1, pulse TMO cycles later.
        check_eq("tmo_delay", 32'(err_cyc - last_rd_cyc), 32'(2 + TMO));
        check_eq("tmo_code", 32'(last_code), 32'd3);
        check_eq("tmo_cnt", 32'(err_cnt), 32'd3);

        // Backpressure: two frames queued back-to-back
        push_bytes(64'h00AA010310203002, 7);
        push_bytes(64'h0000AA0302112232, 6);
        wait_valid("bp1");
        p0 = pop_in_hold;
        r0 = rd_ptr;
        repeat (20) tick();
        check_eq("bp_rd_en", 32'(fifo_rd_en), 32'd0);
        check_eq("bp_no_pop", 32'(pop_in_hold), 32'(p0));
        check_eq("bp_fifo_untouched", 32'(rd_ptr), 32'(r0));
        check_eq("bp_cmd_hold", 32'(frame_cmd), 32'h01);
        read_buf(6'd1, d); check_eq("bp_buf1_hold", 32'(d), 32'h20);
        ack("bp1");
        wait_valid("bp2");
        check_eq("bp2_cmd", 32'(frame_cmd), 32'h03);
        check_eq("bp2_len", 32'(frame_len), 32'd2);
        read_buf(6'd0, d); check_eq("bp2_buf0", 32'(d), 32'h11);
        read_buf(6'd1, d); check_eq("bp2_buf1", 32'(d), 32'h22);
        check_eq("bp2_good", 32'(good_cnt), 32'd5);
        check_eq("bp_hold_pops", 32'(pop_in_hold), 32'(p0));
        ack("bp2");

        // Reset in the middle of a payload
        push_bytes(64'h00000000AA070310, 4);
        drain(2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_vals("midrst");
        push_bytes(64'h000000AA09024455, 5);
        push(8'h1A);
        wait_valid("post");
        check_eq("post_cmd", 32'(frame_cmd), 32'h09);
        check_eq("post_len", 32'(frame_len), 32'd2);
        read_buf(6'd0, d); check_eq("post_buf0", 32'(d), 32'h44);
        read_buf(6'd1, d); check_eq("post_buf1", 32'(d), 32'h55);
        check_eq("post_good", 32'(good_cnt), 32'd1);
        check_eq("post_errcnt", 32'(err_cnt), 32'd0);
        ack("post");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_frame_parser.md
Name: uart_frame_parser

Overview:
- Sits directly downstream of the UART receive FIFO and consumes its byte stream.
- Pops bytes through the FIFO read handshake, finds frames, checks length and checksum, and stores the payload in an internal buffer.
- Presents each good frame (cmd, len, payload) to the command layer and holds it until acknowledged.
- Bad frames are dropped, reported with an error pulse and code, and counted.
- Frame format: SOF 0xAA, CMD, LEN, LEN payload bytes, CHK. CHK = XOR of CMD, LEN and all payload bytes.

Parameters:
- MAX_LEN, 64, largest accepted LEN (1..255); also the payload buffer depth.
- TIMEOUT_CLKS, 480000, inter-byte timeout in clk cycles once SOF has been seen (10 ms at 48 MHz).
- ADDR_W, 6, buffer address width; must satisfy 2^ADDR_W >= MAX_LEN.

Ports:
- clk  in  1  single clock for the whole block.
- rst  in  1  reset; synchronous and active-high.
- fifo_rd_en  out  1  pop request to the RX FIFO, one-cycle pulse.
- fifo_dout  in  8  FIFO data; valid the cycle after fifo_rd_en.
- fifo_empty  in  1  FIFO empty flag.
- frame_valid  out  1  a good frame is held (level).
- frame_cmd  out  8  CMD of the held frame.
- frame_len  out  8  LEN of the held frame.
- buf_raddr  in  ADDR_W  payload read address.
- buf_rdata  out  8  payload byte; registered, valid 1 cycle after buf_raddr.
- frame_ack  in  1  releases the held frame.
- err_pulse  out  1  one-cycle pulse when a frame is dropped.
- err_code  out  2  error cause: 1 = LEN > MAX_LEN, 2 = bad CHK, 3 = timeout. Valid with err_pulse; holds its last value otherwise.
- good_cnt  out  16  good frames received; saturates at 0xFFFF.
- err_cnt  out  16  dropped frames; saturates at 0xFFFF.

Behaviour:
- Reset (rst=1 at a clk edge):
  - Outputs: fifo_rd_en, frame_valid, err_pulse = 0; frame_cmd, frame_len, err_code, good_cnt, err_cnt = 0.
  - State: FSM goes to IDLE; pending flag and timeout counter are cleared.
  - Reset mid-frame discards the partial frame. A byte whose pop is in flight is lost, and this is accepted.
- Pop handshake:
  - fifo_rd_en=1 only when fifo_empty=0, no pop is pending, and state != HOLD.
  - Once a pop is issued, the pending flag is set; the byte is consumed from fifo_dout on the next cycle and the flag clears.
  - Only one pop is outstanding at a time, so the maximum rate is one byte per 2 clk. No pop is ever issued in HOLD.
- FSM states: IDLE, CMD, LEN, PAYLOAD, CHK, HOLD. Transitions apply only on a consumed byte, except timeout and ack.
  - IDLE: byte 0xAA → CMD. Any other byte is discarded silently, with no error.
  - CMD: store frame_cmd and set chk_acc = byte → LEN.
  - LEN: if byte > MAX_LEN, err code 1 → IDLE. If byte = 0 → CHK. Otherwise → PAYLOAD. In the non-error cases, store frame_len, chk_acc ^= byte, and clear the write index.
  - PAYLOAD: write byte to buf[idx], chk_acc ^= byte, idx++. When idx reaches LEN-1 → CHK.
  - CHK: if byte == chk_acc, go to HOLD with frame_valid=1 from the next cycle and good_cnt++. Otherwise err code 2 → IDLE.
  - HOLD: frame_valid=1 and the buffer is frozen. frame_ack=1 → IDLE, with frame_valid=0 the next cycle. frame_ack is ignored outside HOLD.
- Timeout:
  - The counter reloads on every consumed byte and runs only in CMD, LEN, PAYLOAD and CHK.
  - When it reaches TIMEOUT_CLKS: err code 3 → IDLE.
  - If a byte is consumed in the same cycle as expiry, the byte wins and no timeout occurs.
- Error reporting:
  - Every drop asserts err_pulse for 1 cycle, sets err_code, and increments err_cnt.
  - No new SOF search begins until the FSM is back in IDLE.
- Buffer:
  - Single write port (parser) and single read port (buf_raddr). buf_rdata is registered.
  - Contents are undefined outside HOLD.
  - Reads at addresses >= frame_len return stale data; this is legal and not checked.

Decomposition:
- Package uart_frame_pkg holds:
  - SOF constant 0xAA.
  - FSM state encoding.
  - err_code constants ERR_LEN = 1, ERR_CHK = 2, ERR_TMO = 3.
- One sub-module: frame_payload_ram. It is a simple dual-port MAX_LEN x 8 memory with a registered read, inferable to EBR.

Test Plan:
- Good frame: FIFO holds AA 01 03 10 20 30 02 → frame_valid=1, cmd=0x01, len=3, buf[0..2] = 10,20,30, good_cnt=1, err_pulse never asserted.
- Bad checksum: AA 01 03 10 20 30 03 → err_pulse with err_code=2, err_cnt=1, frame_valid stays 0.
- LEN=0 and oversize LEN:
  - AA 05 00 05 → frame_valid=1, len=0.
  - AA 01 41 → err_code=1. The following bytes are hunted for SOF again.
- Garbage and timeout:
  - 55 00 AA 02 01 7E 7D → garbage discarded, frame accepted with cmd=0x02, no error.
  - AA 01 followed by no more data → exactly TIMEOUT_CLKS cycles after the last consumed byte, err_code=3.
- Backpressure: two good frames queued back-to-back.
  - While the first frame is held, fifo_rd_en=0 and payload/cmd are unchanged.
  - frame_ack → the second frame is parsed and good_cnt=2.
- Reset mid-PAYLOAD: assert rst for 1 cycle → all outputs at reset values and the FSM is in IDLE. A subsequent full frame parses correctly.
